// File: rtl/time_syn_tx_arb.sv
// time_syn_tx_arb
// Shares one 64-bit AXI-Stream TX link between the three time-sync frame
// sources: timestamp (TS), standard time (STD) and return timestamp (RET).
// Each granted frame is two beats: a preamble word that identifies the frame
// type to the peer receiver, then the 64-bit payload with tlast.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_<ch>_req / i_<ch>_data        1-cycle request pulse + payload (latched on req)
//   o_<ch>_ack                      1-cycle pulse on the payload handshake
//   o_tx_axis_*, i_tx_axis_tready   AXIS master towards the MAC
//   o_ovwr_cnt                      saturating count of overwritten pending requests
//
// state | meaning
// IDLE  | nothing in flight, grant round-robin when any channel is pending
// PRE   | preamble beat presented, waiting for tready
// PAY   | payload beat presented (tlast=1), waiting for tready
// GAP   | forced inter-frame idle, P_IFG cycles

module time_syn_tx_arb #(
    parameter int unsigned P_IFG     = 4,
    parameter logic [63:0] P_TS_PRE  = 64'h66,
    parameter logic [63:0] P_STD_PRE = 64'h88,
    parameter logic [63:0] P_RET_PRE = 64'h55
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ts_req,
    input  logic [63:0] i_ts_data,
    output logic        o_ts_ack,
    input  logic        i_std_req,
    input  logic [63:0] i_std_data,
    output logic        o_std_ack,
    input  logic        i_ret_req,
    input  logic [63:0] i_ret_data,
    output logic        o_ret_ack,
    output logic        o_tx_axis_tvalid,
    output logic [63:0] o_tx_axis_tdata,
    output logic        o_tx_axis_tlast,
    output logic [7:0]  o_tx_axis_tkeep,
    output logic        o_tx_axis_tuser,
    input  logic        i_tx_axis_tready,
    output logic [15:0] o_ovwr_cnt
);

    localparam int            GW       = $clog2(P_IFG + 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'(P_IFG);
    localparam bit            IFG_NONE = (P_IFG == 0);

    localparam logic [1:0] CH_TS  = 2'd0;
    localparam logic [1:0] CH_STD = 2'd1;
    localparam logic [1:0] CH_RET = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

    function automatic logic [1:0] ch_next(input logic [1:0] ch);
        return (ch == CH_RET) ? CH_TS : ch + 2'd1;
    endfunction

    function automatic logic [63:0] ch_pre(input logic [1:0] ch);
        case (ch)
            CH_STD:  return P_STD_PRE;
            CH_RET:  return P_RET_PRE;
            default: return P_TS_PRE;
        endcase
    endfunction

    state_t        state_q;
    logic [2:0]    pend_q;
    logic [2:0]    pend_d;
    logic [63:0]   data_q [3];
    logic [63:0]   din    [3];
    logic [1:0]    rr_q;        // first channel the next search looks at
    logic [1:0]    gnt_q;       // channel owning the frame in flight
    logic [63:0]   frame_q;
    logic [GW-1:0] gap_q;
    logic [15:0]   ovwr_q;
    logic [15:0]   ovwr_d;
    logic [16:0]   ovwr_sum;
    logic          tvalid_q;
    logic [63:0]   tdata_q;
    logic          tlast_q;
    logic [7:0]    tkeep_q;

    logic [2:0]    req;
    logic [2:0]    clr;
    logic [2:0]    ov;
    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic          pay_hs;
    logic          slot;
    logic          take;

    assign req    = {i_ret_req, i_std_req, i_ts_req};
    assign din[0] = i_ts_data;
    assign din[1] = i_std_data;
    assign din[2] = i_ret_data;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_vld && pend_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
            cand = ch_next(cand);
        end
    end

    assign pay_hs = (state_q == S_PAY) & i_tx_axis_tready;

    // A new grant may be issued in IDLE, on the last gap cycle, or on the
    // payload handshake when there is no gap, so back-to-back frames are
    // separated by exactly P_IFG idle cycles.
    assign slot = (state_q == S_IDLE)
                | ((state_q == S_GAP) & (gap_q == GW'(1)))
                | (IFG_NONE & pay_hs);
    assign take = slot & gnt_vld;

    // A request on the channel being granted re-arms it for a later frame and
    // is not an overwrite, since the previous pending value is being consumed.
    always_comb begin
        clr = 3'b000;
        ov  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            clr[i] = take & (gnt_idx == 2'(i));
            ov[i]  = req[i] & pend_q[i] & ~clr[i];
        end
        pend_d   = req | (pend_q & ~clr);
        ovwr_sum = {1'b0, ovwr_q} + 17'(ov[0]) + 17'(ov[1]) + 17'(ov[2]);
        ovwr_d   = ovwr_sum[16] ? 16'hFFFF : ovwr_sum[15:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 3'b000;
            for (int i = 0; i < 3; i++) data_q[i] <= '0;
            rr_q     <= CH_TS;
            gnt_q    <= CH_TS;
            frame_q  <= '0;
            gap_q    <= '0;
            ovwr_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovwr_q <= ovwr_d;
            for (int i = 0; i < 3; i++) begin
                if (req[i]) data_q[i] <= din[i];
            end

            if (take) begin
                frame_q  <= data_q[gnt_idx];
                gnt_q    <= gnt_idx;
                rr_q     <= ch_next(gnt_idx);
                state_q  <= S_PRE;
                tvalid_q <= 1'b1;
                tdata_q  <= ch_pre(gnt_idx);
                tlast_q  <= 1'b0;
                tkeep_q  <= 8'hFF;
            end else begin
                case (state_q)
                    S_PRE: begin
                        if (i_tx_axis_tready) begin
                            state_q <= S_PAY;
                            tdata_q <= frame_q;
                            tlast_q <= 1'b1;
                        end
                    end
                    S_PAY: begin
                        if (i_tx_axis_tready) begin
                            state_q  <= IFG_NONE ? S_IDLE : S_GAP;
                            gap_q    <= GAP_LOAD;
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tlast_q  <= 1'b0;
                            tkeep_q  <= '0;
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GW'(1)) state_q <= S_IDLE;
                        else                 gap_q   <= gap_q - GW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ts_ack         = pay_hs & (gnt_q == CH_TS);
    assign o_std_ack        = pay_hs & (gnt_q == CH_STD);
    assign o_ret_ack        = pay_hs & (gnt_q == CH_RET);
    assign o_tx_axis_tvalid = tvalid_q;
    assign o_tx_axis_tdata  = tdata_q;
    assign o_tx_axis_tlast  = tlast_q;
    assign o_tx_axis_tkeep  = tkeep_q;
    assign o_tx_axis_tuser  = 1'b0;
    assign o_ovwr_cnt       = ovwr_q;

endmodule

// File: tb/tb_time_syn_tx_arb.sv
// Bench for time_syn_tx_arb: a table of simultaneous-request patterns with
// their expected grant order, plus hand sequences for latency, backpressure,
// overwrite counting/saturation and reset mid-frame. Expected AXIS beats are
// queued when requests are driven and popped by a monitor on each handshake.

module tb_time_syn_tx_arb;

    localparam int          P_IFG   = 4;
    localparam logic [63:0] PRE_TS  = 64'h66;
    localparam logic [63:0] PRE_STD = 64'h88;
    localparam logic [63:0] PRE_RET = 64'h55;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ts_req = 1'b0, std_req = 1'b0, ret_req = 1'b0;
    logic [63:0] ts_data = '0, std_data = '0, ret_data = '0;
    logic        ts_ack, std_ack, ret_ack;
    logic        tvalid, tlast, tuser;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tready = 1'b0;
    logic [15:0] ovwr;

    always #5 clk = ~clk;

    time_syn_tx_arb #(
        .P_IFG(P_IFG), .P_TS_PRE(PRE_TS), .P_STD_PRE(PRE_STD), .P_RET_PRE(PRE_RET)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ts_req(ts_req),   .i_ts_data(ts_data),   .o_ts_ack(ts_ack),
        .i_std_req(std_req), .i_std_data(std_data), .o_std_ack(std_ack),
        .i_ret_req(ret_req), .i_ret_data(ret_data), .o_ret_ack(ret_ack),
        .o_tx_axis_tvalid(tvalid), .o_tx_axis_tdata(tdata), .o_tx_axis_tlast(tlast),
        .o_tx_axis_tkeep(tkeep), .o_tx_axis_tuser(tuser), .i_tx_axis_tready(tready),
        .o_ovwr_cnt(ovwr)
    );

    typedef struct { logic [63:0] data; logic last; logic [2:0] ack; } beat_t;
    beat_t sb_q[$];

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    int hs_cnt = 0, ack_cnt = 0, last_end = 0;
    bit have_end = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pre_of(input int ch);
        case (ch)
            0:       return PRE_TS;
            1:       return PRE_STD;
            default: return PRE_RET;
        endcase
    endfunction

    task automatic push_frame(input int ch, input logic [63:0] d);
        beat_t b;
        b.data = pre_of(ch); b.last = 1'b0; b.ack = 3'b000;
        sb_q.push_back(b);
        b.data = d; b.last = 1'b1; b.ack = 3'(1 << ch);
        sb_q.push_back(b);
    endtask

    // Monitor: compares every handshake against the scoreboard head, checks
    // that acks occur only with payload handshakes and checks frame spacing.
    always @(negedge clk) begin
        logic [2:0] acks;
        beat_t      b;
        acks = {ret_ack, std_ack, ts_ack};
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (tvalid && !prev_valid && have_end)
                chk("ifg_spacing", 64'(cyc - last_end), 64'(P_IFG + 1));
            if (tvalid && tready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got tdata %h expected no beat", tdata);
                end else begin
                    b = sb_q.pop_front();
                    chk("tdata", tdata, b.data);
                    chk("tlast", 64'(tlast), 64'(b.last));
                    chk("tkeep", 64'(tkeep), 64'hFF);
                    chk("tuser", 64'(tuser), 64'h0);
                    chk("ack", 64'(acks), 64'(b.ack));
                end
                if (tlast) begin
                    last_end = cyc;
                    have_end = 1'b1;
                end
            end else if (acks != 3'b000) begin
                n_total++;
                $display("FAIL ack_no_handshake: got ack %b expected 000", acks);
            end
            if (acks != 3'b000) ack_cnt++;
            prev_valid = tvalid;
        end
    end

    task automatic pulse(input logic [2:0] m, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2);
        @(posedge clk); #1;
        ts_req = m[0]; std_req = m[1]; ret_req = m[2];
        ts_data = d0; std_data = d1; ret_data = d2;
        @(posedge clk); #1;
        ts_req = 1'b0; std_req = 1'b0; ret_req = 1'b0;
        ts_data = ~d0; std_data = ~d1; ret_data = ~d2;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (P_IFG + 3) @(posedge clk);
        have_end = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!tvalid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!tvalid) begin
            n_total++;
            $display("FAIL %s: got tvalid=0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    typedef struct { logic [2:0] req; int n; int o0; int o1; int o2; } vec_t;
    vec_t vt [6];

    initial begin
        logic [63:0] d [3];
        logic [63:0] last_d [3];
        logic [63:0] d_t;
        int ord [3];
        int h0, a0, exp_ovwr, sat_iters;
        logic [2:0] pm;
        bit mid_done;

        // req mask, frame count, expected grant order (0=TS 1=STD 2=RET)
        vt[0] = '{3'b001, 1, 0, 0, 0};
        vt[1] = '{3'b100, 1, 2, 0, 0};
        vt[2] = '{3'b111, 3, 0, 1, 2};
        vt[3] = '{3'b101, 2, 0, 2, 0};
        vt[4] = '{3'b011, 2, 0, 1, 0};
        vt[5] = '{3'b110, 2, 2, 1, 0};
        exp_ovwr = 0;

        #12;
        chk("rst_tvalid", 64'(tvalid), 64'h0);
        chk("rst_tdata", tdata, 64'h0);
        chk("rst_tlast", 64'(tlast), 64'h0);
        chk("rst_tkeep", 64'(tkeep), 64'h0);
        chk("rst_ovwr", 64'(ovwr), 64'h0);
        chk("rst_acks", 64'({ret_ack, std_ack, ts_ack}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 3; c++) d[c] = {$urandom, $urandom};
            ord[0] = vt[i].o0; ord[1] = vt[i].o1; ord[2] = vt[i].o2;
            for (int k = 0; k < vt[i].n; k++) push_frame(ord[k], d[ord[k]]);
            pulse(vt[i].req, d[0], d[1], d[2]);
            drain(200);
        end
        chk("ovwr_after_table", 64'(ovwr), 64'(exp_ovwr));

        // latency: req sampled at edge N, preamble valid in cycle N+2
        push_frame(0, 64'h1122334455667788);
        pulse(3'b001, 64'h1122334455667788, 64'h0, 64'h0);
        @(negedge clk);
        chk("latency_n1_tvalid", 64'(tvalid), 64'h0);
        @(negedge clk);
        chk("latency_n2_tvalid", 64'(tvalid), 64'h1);
        chk("latency_n2_tdata", tdata, PRE_TS);
        drain(100);

        // backpressure: 5 stalled cycles on each beat
        tready = 1'b0;
        d_t = {$urandom, $urandom};
        h0 = hs_cnt; a0 = ack_cnt;
        push_frame(1, d_t);
        pulse(3'b010, 64'h0, d_t, 64'h0);
        wait_valid("stall_pre_valid", 20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pre_tvalid", 64'(tvalid), 64'h1);
            chk("stall_pre_tdata", tdata, PRE_STD);
            chk("stall_pre_tlast", 64'(tlast), 64'h0);
        end
        @(posedge clk); #1 tready = 1'b1;
        @(posedge clk); #1 tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pay_tvalid", 64'(tvalid), 64'h1);
            chk("stall_pay_tdata", tdata, d_t);
            chk("stall_pay_tlast", 64'(tlast), 64'h1);
        end
        @(posedge clk); #1 tready = 1'b1;
        drain(100);
        chk("stall_handshakes", 64'(hs_cnt - h0), 64'd2);
        chk("stall_acks", 64'(ack_cnt - a0), 64'd1);

        // two RET requests while a TS frame is stalled: latest wins, one overwrite
        tready = 1'b0;
        d_t = {$urandom, $urandom};
        d[0] = {$urandom, $urandom};
        d[1] = {$urandom, $urandom};
        push_frame(0, d_t);
        push_frame(2, d[1]);
        pulse(3'b001, d_t, 64'h0, 64'h0);
        pulse(3'b100, 64'h0, 64'h0, d[0]);
        pulse(3'b100, 64'h0, 64'h0, d[1]);
        exp_ovwr = exp_ovwr + 1;
        chk("ovwr_ret_twice", 64'(ovwr), 64'(exp_ovwr));
        tready = 1'b1;
        drain(200);

        // saturation: all channels overwritten every cycle behind a stalled frame;
        // the TS req on the grant edge re-arms TS without counting
        tready = 1'b0;
        d_t = {$urandom, $urandom};
        push_frame(0, d_t);
        pulse(3'b001, d_t, 64'h0, 64'h0);
        ts_req = 1'b1; std_req = 1'b1; ret_req = 1'b1;
        pm = 3'b000;
        sat_iters = 0;
        mid_done = 1'b0;
        while (sat_iters < 4) begin
            ts_data = {$urandom, $urandom};
            std_data = {$urandom, $urandom};
            ret_data = {$urandom, $urandom};
            last_d[0] = ts_data; last_d[1] = std_data; last_d[2] = ret_data;
            @(posedge clk);
            exp_ovwr = exp_ovwr + $countones(pm);
            if (exp_ovwr > 65535) exp_ovwr = 65535;
            pm = 3'b111;
            #1;
            if (!mid_done && exp_ovwr >= 65520 && exp_ovwr < 65535) begin
                chk("ovwr_near_sat", 64'(ovwr), 64'(exp_ovwr));
                mid_done = 1'b1;
            end
            if (exp_ovwr == 65535) sat_iters++;
        end
        ts_req = 1'b0; std_req = 1'b0; ret_req = 1'b0;
        chk("ovwr_saturated", 64'(ovwr), 64'hFFFF);
        push_frame(1, last_d[1]);
        push_frame(2, last_d[2]);
        push_frame(0, last_d[0]);
        tready = 1'b1;
        drain(300);
        chk("ovwr_held", 64'(ovwr), 64'hFFFF);

        // reset during a stalled payload beat, with STD pending behind it
        tready = 1'b0;
        d_t = {$urandom, $urandom};
        push_frame(0, d_t);
        pulse(3'b001, d_t, 64'h0, 64'h0);
        wait_valid("rst_seq_valid", 20);
        @(posedge clk); #1;
        tready = 1'b1;
        std_req = 1'b1;
        std_data = {$urandom, $urandom};
        @(posedge clk); #1;
        tready = 1'b0;
        std_req = 1'b0;
        #2;
        tready = 1'b1;
        rst = 1'b1;
        sb_q.delete();
        have_end = 1'b0;
        exp_ovwr = 0;
        #1;
        chk("midrst_tvalid", 64'(tvalid), 64'h0);
        chk("midrst_tlast", 64'(tlast), 64'h0);
        chk("midrst_acks", 64'({ret_ack, std_ack, ts_ack}), 64'h0);
        chk("midrst_ovwr", 64'(ovwr), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        h0 = hs_cnt;
        repeat (10) @(posedge clk);
        chk("no_frame_after_rst", 64'(hs_cnt - h0), 64'h0);
        d_t = {$urandom, $urandom};
        push_frame(0, d_t);
        pulse(3'b001, d_t, 64'h0, 64'h0);
        drain(100);
        chk("ovwr_after_rst", 64'(ovwr), 64'(exp_ovwr));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
